// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Packet-locked round-robin arbiter that funnels byte streams from NUM_REQ
//   requesters into a single UART transmitter. A granted requester keeps the
//   transmitter until its last byte goes out or it stalls for TIMEOUT cycles.
//   After every byte the block waits for the transmitter to go busy and come
//   back idle, so a byte is never issued twice.
//
//   Optional feature: define UART_ARB_TAG_EN to prefix every packet with a
//   header byte {4'hA, 1'b0, grant_id}.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_data        byte i of requester i at [8i+7:8i]
//   req_valid       requester i presents a byte
//   req_last        the presented byte ends its packet
//   req_ready       byte of requester i accepted this cycle
//   tx_data         byte to the UART transmitter
//   tx_data_valid   tx_data is valid (a transfer when high)
//   tx_data_ready   transmitter idle and able to accept a byte
//   grant_id        index of the current owner
//   busy            arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
`ifdef UART_ARB_TAG_EN
        ST_HDR     = 3'd1,
`endif
        ST_SEND    = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_t;

    state_t       state_r,      state_s;
    logic [2:0]   grant_r,      grant_s;
    logic [2:0]   last_owner_r, last_owner_s;
    logic [15:0]  stall_r,      stall_s;
    logic         last_flag_r,  last_flag_s;

    logic [2:0]         rr_winner_s;
    logic               rr_found_s;
    logic [7:0]         sel_data_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic [7:0]         tx_data_s;
    logic               tx_valid_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // Round-robin search: first valid requester starting at last_owner+1.
    always_comb begin
        logic take_v;
        take_v      = 1'b0;
        rr_found_s  = 1'b0;
        rr_winner_s = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                take_v      = !rr_found_s && req_valid[i] &&
                              (i == ((int'(last_owner_r) + k) % NUM_REQ));
                rr_winner_s = take_v ? 3'(i) : rr_winner_s;
                rr_found_s  = rr_found_s | take_v;
            end
        end
    end

    // AND-OR mux selecting the granted requester's byte, valid and last.
    always_comb begin
        logic hit_v;
        hit_v       = 1'b0;
        sel_data_s  = 8'h00;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_v       = (grant_r == 3'(i));
            sel_data_s  = sel_data_s | (req_data[i*8 +: 8] & {8{hit_v}});
            sel_valid_s = sel_valid_s | (req_valid[i] & hit_v);
            sel_last_s  = sel_last_s | (req_last[i] & hit_v);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_owner_s = last_owner_r;
        stall_s      = stall_r;
        last_flag_s  = last_flag_r;
        tx_data_s    = 8'h00;
        tx_valid_s   = 1'b0;
        req_ready_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (rr_found_s) begin
                    grant_s = rr_winner_s;
                    stall_s = 16'd0;
`ifdef UART_ARB_TAG_EN
                    state_s = ST_HDR;
`else
                    state_s = ST_SEND;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_HDR: begin
                tx_data_s  = {4'hA, 1'b0, grant_r};
                tx_valid_s = tx_data_ready;
                if (tx_data_ready) begin
                    // Payload follows the header, so nothing is "last" yet.
                    last_flag_s = 1'b0;
                    state_s     = ST_WAIT_LO;
                end else begin
                    state_s = ST_HDR;
                end
            end
`endif
            ST_SEND: begin
                tx_data_s  = sel_data_s;
                tx_valid_s = sel_valid_s & tx_data_ready;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready_s[i] = tx_valid_s & (grant_r == 3'(i));
                end
                if (tx_valid_s) begin
                    last_flag_s = sel_last_s;
                    stall_s     = 16'd0;
                    state_s     = ST_WAIT_LO;
                end else if (!sel_valid_s) begin
                    if (stall_r == (TIMEOUT - 16'd1)) begin
                        // Owner went silent: revoke without sending anything.
                        last_owner_s = grant_r;
                        stall_s      = 16'd0;
                        state_s      = ST_IDLE;
                    end else begin
                        stall_s = stall_r + 16'd1;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT_LO: begin
                // Transmitter must visibly take the byte before we move on.
                if (!tx_data_ready) begin
                    state_s = ST_WAIT_HI;
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (tx_data_ready) begin
                    if (last_flag_r) begin
                        last_owner_s = grant_r;
                        state_s      = ST_IDLE;
                    end else begin
                        stall_s = 16'd0;
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= 3'd0;
            last_owner_r <= 3'd0;
            stall_r      <= 16'd0;
            last_flag_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_owner_r <= last_owner_s;
            stall_r      <= stall_s;
            last_flag_r  <= last_flag_s;
        end
    end

    assign tx_data       = tx_data_s;
    assign tx_data_valid = tx_valid_s;
    assign req_ready     = req_ready_s;
    assign grant_id      = grant_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Requesters are byte queues, the transmitter is an emulator that goes busy
//   for a few cycles after each byte. Expected output streams are built from
//   packet lists and the round-robin rule at packet granularity.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int          NUM_REQ = 4;
    localparam logic [15:0] TIMEOUT = 16'd10;
    localparam int          MEM_D   = 64;
`ifdef UART_ARB_TAG_EN
    localparam int          HDR_N   = 1;
`else
    localparam int          HDR_N   = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;
    logic [2:0]           grant_id;
    logic                 busy;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Requester byte queues: {last, byte}.
    logic [8:0] rq_mem [NUM_REQ][MEM_D];
    int         rq_wr [NUM_REQ];
    int         rq_rd [NUM_REQ];
    int         gap_cnt [NUM_REQ];
    int         ready_cnt [NUM_REQ];
    bit         gap_en = 1'b0;
    int         tx_hold = 0;
    int         tx_busy_min = 2;
    int         tx_busy_max = 2;

    logic [7:0] tx_log [$];
    logic [2:0] gid_log [$];
    logic [7:0] exp_byte [$];
    logic [2:0] exp_gid [$];

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_wr[i] = 0; rq_rd[i] = 0; gap_cnt[i] = 0; ready_cnt[i] = 0;
        end
        tx_log.delete(); gid_log.delete();
        exp_byte.delete(); exp_gid.delete();
        tx_hold = 0;
    endtask

    task automatic load(input int id, input logic [7:0] b, input logic last);
        rq_mem[id][rq_wr[id]] = {last, b};
        rq_wr[id]++;
    endtask

    task automatic exp_pkt(input int id);
        logic [2:0] id3;
        id3 = 3'(id);
        if (HDR_N != 0) begin
            exp_byte.push_back({4'hA, 1'b0, id3});
            exp_gid.push_back(id3);
        end
    endtask

    task automatic exp_b(input int id, input logic [7:0] b);
        exp_byte.push_back(b);
        exp_gid.push_back(3'(id));
    endtask

    // Transmitter emulator and requester drivers.
    initial begin : driver
        req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_wr[i] = 0; rq_rd[i] = 0; gap_cnt[i] = 0; ready_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (tx_data_valid) begin
                check_eq("valid_without_ready", 32'(tx_data_ready), 32'd1);
                tx_log.push_back(tx_data);
                gid_log.push_back(grant_id);
                tx_hold = $urandom_range(tx_busy_max, tx_busy_min);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    check_eq($sformatf("ready_without_valid%0d", i), 32'(req_valid[i]), 32'd1);
                    ready_cnt[i]++;
                    if (rq_rd[i] < rq_wr[i]) begin
                        if (gap_en && !rq_mem[i][rq_rd[i]][8]) gap_cnt[i] = $urandom_range(2, 0);
                        rq_rd[i]++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (tx_hold > 0) begin
                tx_data_ready = 1'b0;
                tx_hold--;
            end else begin
                tx_data_ready = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                    req_valid[i] = 1'b0; req_last[i] = 1'b0;
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (rq_rd[i] < rq_wr[i]) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = rq_mem[i][rq_rd[i]][8];
                    req_data[i*8 +: 8] = rq_mem[i][rq_rd[i]][7:0];
                end else begin
                    req_valid[i] = 1'b0; req_last[i] = 1'b0;
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, " busy"},          32'(busy),          32'd0);
        check_eq({tag, " tx_data_valid"}, 32'(tx_data_valid), 32'd0);
        check_eq({tag, " req_ready"},     32'(req_ready),     32'd0);
        check_eq({tag, " grant_id"},      32'(grant_id),      32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (tx_log.size() < n && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, " bytes_reached"}, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (!(tx_log.size() >= exp_byte.size() && busy == 1'b0 && tx_hold == 0) && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        repeat (4) @(negedge clk);
        #1;
        check_eq({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_logs(input string tag);
        int n;
        check_eq({tag, " count"}, 32'(tx_log.size()), 32'(exp_byte.size()));
        n = (tx_log.size() < exp_byte.size()) ? tx_log.size() : exp_byte.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s byte%0d", tag, i), 32'(tx_log[i]),  32'(exp_byte[i]));
            check_eq($sformatf("%s gid%0d", tag, i),  32'(gid_log[i]), 32'(exp_gid[i]));
        end
    endtask

    // Packet lists for the randomized rounds.
    int         pk_cnt [NUM_REQ];
    int         pk_len [NUM_REQ][4];
    logic [7:0] pk_dat [NUM_REQ][4][4];

    initial begin : main
        int stall;
        int cyc;
        int nxt [NUM_REQ];
        int last_own;
        int win;
        bit found;

        // Reset state.
        do_reset();

        // Single requester, two-byte packet.
        do_reset();
        exp_pkt(2); exp_b(2, 8'h55); exp_b(2, 8'h66);
        load(2, 8'h55, 1'b0); load(2, 8'h66, 1'b1);
        wait_done(300, "s1");
        compare_logs("s1");
        for (int i = 0; i < NUM_REQ; i++)
            check_eq($sformatf("s1 ready_cnt%0d", i), 32'(ready_cnt[i]), (i == 2) ? 32'd2 : 32'd0);

        // Simultaneous 0 and 1 after reset: 1 wins first.
        do_reset();
        load(0, 8'h10, 1'b1); load(1, 8'h20, 1'b1);
        exp_pkt(1); exp_b(1, 8'h20);
        exp_pkt(0); exp_b(0, 8'h10);
        wait_done(300, "s2");
        compare_logs("s2");

        // Requester 0 arrives while 3 is mid-packet.
        do_reset();
        load(3, 8'h30, 1'b0); load(3, 8'h31, 1'b0); load(3, 8'h32, 1'b0); load(3, 8'h33, 1'b1);
        exp_pkt(3); exp_b(3, 8'h30); exp_b(3, 8'h31); exp_b(3, 8'h32); exp_b(3, 8'h33);
        exp_pkt(0); exp_b(0, 8'h40);
        wait_log(HDR_N + 1, 300, "s3");
        load(0, 8'h40, 1'b1);
        wait_done(400, "s3");
        compare_logs("s3");

        // Owner goes silent after one non-last byte: timeout.
        do_reset();
        load(2, 8'h5A, 1'b0);
        exp_pkt(2); exp_b(2, 8'h5A);
        wait_log(HDR_N + 1, 300, "s4");
        stall = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            if (busy && tx_data_ready) stall++;
            cyc++;
        end while (busy && cyc < 200);
        // One WAIT_HI cycle that sees the transmitter return, then TIMEOUT stalled SEND cycles.
        check_eq("s4 stall_cycles", 32'(stall), 32'(TIMEOUT) + 32'd1);
        check_eq("s4 bytes_after_timeout", 32'(tx_log.size()), 32'(HDR_N + 1));
        check_eq("s4 ready_cnt2", 32'(ready_cnt[2]), 32'd1);
        // last_owner is now 2, so 3 outranks 1.
        load(3, 8'h73, 1'b1); load(1, 8'h71, 1'b1);
        exp_pkt(3); exp_b(3, 8'h73);
        exp_pkt(1); exp_b(1, 8'h71);
        wait_done(400, "s4");
        compare_logs("s4");

        // Reset pulse in WAIT_HI: no replay of the first byte.
        do_reset();
        load(1, 8'hC1, 1'b0); load(1, 8'hC2, 1'b1);
        exp_pkt(1); exp_b(1, 8'hC1);
        exp_pkt(1); exp_b(1, 8'hC2);
        wait_log(HDR_N + 1, 300, "s5");
        @(posedge clk);   // byte accepted, WAIT_LO
        @(posedge clk);   // transmitter busy seen, WAIT_HI
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("s5 midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_done(400, "s5");
        compare_logs("s5");

        // Randomized rounds against a packet-level round-robin model.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gap_en = 1'b1;
            tx_busy_min = 1;
            tx_busy_max = 3;
            for (int i = 0; i < NUM_REQ; i++) begin
                pk_cnt[i] = $urandom_range(3, 0);
                for (int p = 0; p < pk_cnt[i]; p++) begin
                    pk_len[i][p] = $urandom_range(4, 1);
                    for (int b = 0; b < pk_len[i][p]; b++) begin
                        pk_dat[i][p][b] = 8'($urandom);
                        load(i, pk_dat[i][p][b], (b == pk_len[i][p] - 1));
                    end
                end
                nxt[i] = 0;
            end
            last_own = 0;
            for (int g = 0; g < NUM_REQ * 4; g++) begin
                found = 1'b0;
                win = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && nxt[(last_own + k) % NUM_REQ] < pk_cnt[(last_own + k) % NUM_REQ]) begin
                        win = (last_own + k) % NUM_REQ;
                        found = 1'b1;
                    end
                end
                if (!found) break;
                exp_pkt(win);
                for (int b = 0; b < pk_len[win][nxt[win]]; b++) exp_b(win, pk_dat[win][nxt[win]][b]);
                nxt[win]++;
                last_own = win;
            end
            wait_done(5000, $sformatf("rnd%0d", r));
            compare_logs($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
